decimal_countdown_timer: RTL and testbench
==========================================

# decimal_countdown_timer

Multi-digit BCD down-counter with load, start/stop control and expiry signalling. It is the counting-down counterpart of the team's decimal up-counter digits, used for software-programmed timeouts and for countdown values shown on the BCD/seven-segment display path. It sits on the peripheral side, is loaded from a bus-facing register, and advances on an externally supplied tick strobe, e.g. a 1 kHz or 1 Hz prescaler output.

## Interface
- `NR_DIGITS`, default 4: number of BCD digits, legal range 1..8.
- `clock` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `load` input 1: load `loadValue` into the count and reload registers.
- `loadValue` input 4*NR_DIGITS: BCD value; digit 0 is bits [3:0].
- `start` input 1: begin or resume counting.
- `stop` input 1: pause counting.
- `tick` input 1: single-cycle count strobe.
- `countValue` output 4*NR_DIGITS: current BCD count, registered.
- `running` output 1: high while in state RUNNING.
- `isZero` output 1: combinational, high when `countValue` == 0.
- `expired` output 1: registered expiry pulse, exactly 1 cycle wide.

## Operation
- States: IDLE, RUNNING, EXPIRED.
- Reset: count = 0, reload = 0, state IDLE, `running` = 0, `expired` = 0.
- Control priority, per cycle: reset > load > stop > start > tick.
- load, from any state:
  - count <= `loadValue` and reload <= `loadValue`; state -> IDLE.
  - Any digit > 9 is clamped to 9 in both registers.
  - A `tick` in the same cycle is ignored.
- stop in RUNNING: state -> IDLE with the count held, so a later `start` resumes. stop in other states has no effect.
- start in IDLE:
  - count != 0: state -> RUNNING.
  - count == 0: state -> EXPIRED and `expired` pulses.
- start in RUNNING or EXPIRED: no effect.
- tick in RUNNING: count decrements by 1 using BCD borrow.
  - Digit i wraps 0 -> 9 and borrows from digit i+1 only when digits 0..i are all 0.
  - When the result is 0, state -> EXPIRED and `expired` pulses.
- tick outside RUNNING: ignored. The count never wraps below 0.
- EXPIRED is left only by `load` or `reset`.
- Arithmetic is pure per-digit BCD. No binary intermediate is used. Each digit is always in 0..9.

## Timing
- `load`, `start`, `stop` and `tick` sampled at edge N take effect in the registers after edge N. Outputs reflect them in cycle N+1.
- `expired` is high in the first cycle in which `countValue` reads 0 (or the reload value, see Configuration). It is low in the next cycle, even if the state remains EXPIRED.
- `running` equals (state == RUNNING) and is registered.
- `isZero` follows `countValue` with no added latency.
- A `reset` low during RUNNING or during an `expired` pulse forces the reset values at the next edge. No pulse leaks past reset.
- Back-to-back ticks on consecutive cycles are supported and decrement once per cycle.

## Configuration
- `DECIMAL_COUNTDOWN_AUTORELOAD_EN` defined:
  - A tick in RUNNING that would produce 0 instead loads count <= reload, stays in RUNNING and pulses `expired`.
  - This gives a period of exactly reload ticks.
  - The count never reads 0 while running.
  - start with count == 0 still goes to EXPIRED, so a zero reload cannot run.
- Not defined: the block stops in EXPIRED as described in Operation.

## Test plan
- **Reset:**
  - Stimulus: hold `reset` = 0 for 2 cycles with `load` = 1, `start` = 1, `tick` = 1.
  - Required: `countValue` = 0, `running` = 0, `expired` = 0, `isZero` = 1.
- **Borrow chain (NR_DIGITS = 4):**
  - Stimulus: load 0x1000, start, one tick.
  - Required: `countValue` = 0x0999, `running` = 1.
  - Stimulus: load 0x0100, start, one tick.
  - Required: `countValue` = 0x0099.
- **Expiry:**
  - Stimulus: load 0x0003, start, three ticks on consecutive cycles.
  - Required: `countValue` = 2, 1, 0; `expired` high for 1 cycle aligned with 0.
  - Required afterwards: state EXPIRED, `running` = 0. Further ticks and `start` change nothing.
- **Priority:**
  - Stimulus: in RUNNING at 0x0050, assert `stop` + `tick` together.
  - Required: count stays 0x0050, `running` = 0.
  - Stimulus: `start` again, then `load` 0x0A12 + `tick` together.
  - Required: count = 0x0912, state IDLE.
- **Zero start:**
  - Stimulus: load 0x0000, start.
  - Required: next cycle `expired` = 1 for one cycle, state EXPIRED.
  - Stimulus: reset mid-pulse.
  - Required: `expired` = 0 at the next edge.
- **Autoreload (macro defined):**
  - Stimulus: load 0x0002, start, 6 ticks.
  - Required: `countValue` = 1, 2, 1, 2, 1, 2; `expired` pulses on ticks 2, 4 and 6; `running` stays 1.

Source files
------------

// File: rtl/decimal_countdown_timer_if.sv
// Bus-side signal bundle for decimal_countdown_timer.
// master: the register/control side driving load/start/stop/tick.
// slave : the timer itself, returning count and status.
interface decimal_countdown_timer_if #(
    parameter int NR_DIGITS = 4
);
    logic                   load;
    logic [4*NR_DIGITS-1:0] loadValue;
    logic                   start;
    logic                   stop;
    logic                   tick;
    logic [4*NR_DIGITS-1:0] countValue;
    logic                   running;
    logic                   isZero;
    logic                   expired;

    modport master (
        output load, loadValue, start, stop, tick,
        input  countValue, running, isZero, expired
    );

    modport slave (
        input  load, loadValue, start, stop, tick,
        output countValue, running, isZero, expired
    );
endinterface

// File: rtl/decimal_countdown_timer.sv
// Multi-digit BCD down-counter with load, start/stop and expiry pulse.
// Counts down on an external tick strobe while RUNNING; reaching zero
// moves to EXPIRED and emits a one-cycle registered expired pulse.
// Optional feature macro: DECIMAL_COUNTDOWN_AUTORELOAD_EN -- when defined,
// reaching zero while running reloads the last loaded value and keeps
// running, pulsing expired once per period.
// NR_DIGITS legal range is 1..8; digit 0 occupies bits [3:0].
module decimal_countdown_timer #(
    parameter int NR_DIGITS = 4
) (
    input logic                       clock,
    input logic                       reset,
    decimal_countdown_timer_if.slave  bus
);

    localparam int W = 4 * NR_DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   count_q;
    logic [W-1:0]   count_d;
    logic [W-1:0]   reload_q;
    logic [W-1:0]   reload_d;
    logic [W-1:0]   count_dec;
    logic [W-1:0]   load_clamped;
    logic           dec_zero;
    logic           count_zero;
    logic           running_q;
    logic           expired_q;
    logic           expired_d;

    // Force every digit into 0..9 so the count never holds a non-BCD code.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] value);
        logic [W-1:0] result;
        result = value;
        for (int i = 0; i < NR_DIGITS; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                result[4*i +: 4] = 4'd9;
            end
        end
        return result;
    endfunction

    // Per-digit BCD decrement: a digit wraps 0 -> 9 and passes the borrow
    // upward only while every lower digit was also 0.
    function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] value);
        logic [W-1:0] result;
        logic         borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < NR_DIGITS; i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return result;
    endfunction

    // True when every digit is zero.
    function automatic logic bcd_is_zero(input logic [W-1:0] value);
        logic zero;
        zero = 1'b1;
        for (int i = 0; i < NR_DIGITS; i++) begin
            if (value[4*i +: 4] != 4'd0) begin
                zero = 1'b0;
            end
        end
        return zero;
    endfunction

    // Datapath helpers feeding the next-state logic.
    always_comb begin
        load_clamped = clamp_bcd(bus.loadValue);
        count_dec    = bcd_decrement(count_q);
        dec_zero     = bcd_is_zero(count_dec);
        count_zero   = bcd_is_zero(count_q);
    end

    // Next-state and next-count logic; priority load > stop > start > tick.
    // stop always masks start and tick in its cycle; start only acts in IDLE,
    // so a tick arriving with a redundant start while RUNNING still counts.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;

        if (bus.load) begin
            count_d  = load_clamped;
            reload_d = load_clamped;
            state_d  = IDLE;
        end else if (bus.stop) begin
            if (state_q == RUNNING) begin
                state_d = IDLE;
            end
        end else if (bus.start && state_q == IDLE) begin
            if (count_zero) begin
                state_d   = EXPIRED;
                expired_d = 1'b1;
            end else begin
                state_d = RUNNING;
            end
        end else if (bus.tick && state_q == RUNNING) begin
            if (dec_zero) begin
                expired_d = 1'b1;
`ifdef DECIMAL_COUNTDOWN_AUTORELOAD_EN
                // Reload instead of landing on zero: period is exactly
                // reload ticks and the count never reads 0 while running.
                count_d = reload_q;
                state_d = RUNNING;
`else
                count_d = count_dec;
                state_d = EXPIRED;
`endif
            end else begin
                count_d = count_dec;
            end
        end
    end

    // State, count, reload and registered status outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            running_q <= (state_d == RUNNING);
            expired_q <= expired_d;
        end
    end

    assign bus.countValue = count_q;
    assign bus.running    = running_q;
    assign bus.expired    = expired_q;
    assign bus.isZero     = count_zero;

endmodule

// File: tb/tb_decimal_countdown_timer.sv
// Scoreboard bench for decimal_countdown_timer (NR_DIGITS = 4).
// Stimulus pushes the hand-computed expected outputs for each driven cycle;
// a monitor pops and compares one cycle after the driving edge.
module tb_decimal_countdown_timer;

    logic clock;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;

    typedef struct {
        string       name;
        int          due;
        logic [15:0] cnt;
        logic        run;
        logic        exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    decimal_countdown_timer_if #(.NR_DIGITS(4)) bus ();

    decimal_countdown_timer #(.NR_DIGITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    always @(posedge clock) begin
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s: sample missed, due %0d now %0d", mon_e.name, mon_e.due, cyc);
            end else begin
                check({mon_e.name, ".count"},   bus.countValue,       mon_e.cnt);
                check({mon_e.name, ".running"}, {15'd0, bus.running}, {15'd0, mon_e.run});
                check({mon_e.name, ".expired"}, {15'd0, bus.expired}, {15'd0, mon_e.exp});
                check({mon_e.name, ".isZero"},  {15'd0, bus.isZero},  {15'd0, (mon_e.cnt == 16'h0)});
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input logic rst_n, input logic ld, input logic [15:0] lv,
                        input logic st, input logic sp, input logic tk,
                        input string nm, input logic [15:0] ec,
                        input logic er, input logic ee);
        exp_t e;
        @(negedge clock);
        reset         = rst_n;
        bus.load      = ld;
        bus.loadValue = lv;
        bus.start     = st;
        bus.stop      = sp;
        bus.tick      = tk;
        e.name = nm;
        e.due  = cyc + 1;
        e.cnt  = ec;
        e.run  = er;
        e.exp  = ee;
        sb.push_back(e);
    endtask

    initial begin
        cyc           = 0;
        tests         = 0;
        fails         = 0;
        reset         = 1'b0;
        bus.load      = 1'b0;
        bus.loadValue = 16'h0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.tick      = 1'b0;

        // Reset dominates load/start/tick
        step(0, 1, 16'h1234, 1, 0, 1, "reset0", 16'h0000, 0, 0);
        step(0, 1, 16'h1234, 1, 0, 1, "reset1", 16'h0000, 0, 0);

        // Borrow chain
        step(1, 1, 16'h1000, 0, 0, 0, "b1_load",  16'h1000, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "b1_start", 16'h1000, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "b1_tick",  16'h0999, 1, 0);
        step(1, 1, 16'h0100, 0, 0, 0, "b2_load",  16'h0100, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "b2_start", 16'h0100, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "b2_tick",  16'h0099, 1, 0);

        // Back-to-back ticks across a digit boundary
        step(1, 1, 16'h0011, 0, 0, 0, "bb_load",  16'h0011, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "bb_start", 16'h0011, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "bb_t1",    16'h0010, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "bb_t2",    16'h0009, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "bb_t3",    16'h0008, 1, 0);

`ifndef DECIMAL_COUNTDOWN_AUTORELOAD_EN
        // Expiry: pulse aligned with first zero, then EXPIRED is sticky
        step(1, 1, 16'h0003, 0, 0, 0, "ex_load",  16'h0003, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "ex_start", 16'h0003, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ex_t1",    16'h0002, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ex_t2",    16'h0001, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ex_t3",    16'h0000, 0, 1);
        step(1, 0, 16'h0000, 0, 0, 0, "ex_after", 16'h0000, 0, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ex_tick",  16'h0000, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "ex_start2",16'h0000, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 1, "ex_both",  16'h0000, 0, 0);
`else
        // Autoreload: period of reload ticks, never reads zero
        step(1, 1, 16'h0002, 0, 0, 0, "ar_load",  16'h0002, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "ar_start", 16'h0002, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ar_t1",    16'h0001, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ar_t2",    16'h0002, 1, 1);
        step(1, 0, 16'h0000, 0, 0, 1, "ar_t3",    16'h0001, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ar_t4",    16'h0002, 1, 1);
        step(1, 0, 16'h0000, 0, 0, 1, "ar_t5",    16'h0001, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ar_t6",    16'h0002, 1, 1);
        step(1, 0, 16'h0000, 0, 0, 0, "ar_idle",  16'h0002, 1, 0);
`endif

        // Priority: stop beats tick, load beats tick, load clamps digits
        step(1, 1, 16'h0050, 0, 0, 0, "pr_load",  16'h0050, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "pr_start", 16'h0050, 1, 0);
        step(1, 0, 16'h0000, 0, 1, 1, "pr_stop",  16'h0050, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "pr_resume",16'h0050, 1, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "pr_tick",  16'h0049, 1, 0);
        step(1, 1, 16'h0A12, 0, 0, 1, "pr_ldtick",16'h0912, 0, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "pr_idletk",16'h0912, 0, 0);
        step(1, 1, 16'hFA9B, 0, 0, 0, "pr_clamp", 16'h9999, 0, 0);

        // Zero start and reset during the expired pulse
        step(1, 1, 16'h0000, 0, 0, 0, "z_load",   16'h0000, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "z_start",  16'h0000, 0, 1);
        step(1, 0, 16'h0000, 0, 0, 0, "z_after",  16'h0000, 0, 0);
        step(1, 1, 16'h0000, 0, 0, 0, "z_load2",  16'h0000, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "z_start2", 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 0, 0, "z_reset",  16'h0000, 0, 0);
        step(1, 0, 16'h0000, 0, 0, 0, "z_post",   16'h0000, 0, 0);

        // Reset while RUNNING clears count and reload
        step(1, 1, 16'h0020, 0, 0, 0, "rr_load",  16'h0020, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "rr_start", 16'h0020, 1, 0);
        step(0, 0, 16'h0000, 0, 0, 1, "rr_reset", 16'h0000, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "rr_start0",16'h0000, 0, 1);
        step(1, 0, 16'h0000, 0, 0, 0, "rr_idle",  16'h0000, 0, 0);

        @(negedge clock);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
